// File: rtl/loba0_div_seq.sv
// Sequential approximate divider: leading-one normalisation of both operands,
// a restoring divide of the W-bit windows, then rescale by the exponent difference.
module loba0_div_seq #(
  parameter int N = 16,
  parameter int W = 4,
  parameter int F = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         dbz
);

  localparam int KW = $clog2(N);
  localparam int DW = W + F;
  localparam int CW = $clog2(DW + 1);
  localparam int EW = N + DW;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_SHIFT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [N-1:0]  r_a, r_b, r_q;
  logic [KW-1:0] r_ka, r_kb;
  logic [W-1:0]  r_bh, r_rem;
  logic [DW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_dbz;

  // Highest set bit; a zero operand reports position 0.
  function automatic logic [KW-1:0] lead_one(input logic [N-1:0] x);
    lead_one = '0;
    for (int i = 0; i < N; i++)
      if (x[i]) lead_one = KW'(i);
  endfunction

  logic [KW-1:0] w_ka, w_kb;
  logic [N-1:0]  w_a_shl, w_b_shl;
  logic [W-1:0]  w_ah, w_bh;

  assign w_ka    = lead_one(r_a);
  assign w_kb    = lead_one(r_b);
  assign w_a_shl = r_a << (KW'(N - 1) - w_ka);
  assign w_b_shl = r_b << (KW'(N - 1) - w_kb);
  assign w_ah    = W'(w_a_shl >> (N - W));
  assign w_bh    = W'(w_b_shl >> (N - W));

  // Restoring step: quotient bits shift in from the bottom as dividend bits leave the top.
  logic [W:0]   w_rem_sh;
  logic         w_ge;
  logic [W-1:0] w_rem_next;

  assign w_rem_sh   = {r_rem, r_quo[DW-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_bh});
  assign w_rem_next = w_ge ? W'(w_rem_sh - {1'b0, r_bh}) : W'(w_rem_sh);

  logic [KW+1:0] w_s, w_s_neg;
  logic [EW-1:0] w_qm_ext;
  logic [N-1:0]  w_q_scaled;

  assign w_s      = {2'b00, r_ka} - {2'b00, r_kb} - (KW + 2)'(F);
  assign w_s_neg  = -w_s;
  assign w_qm_ext = EW'(r_quo);

  always_comb begin
    w_q_scaled = '0;
    if (w_s[KW+1]) w_q_scaled = N'(w_qm_ext >> w_s_neg);
    else           w_q_scaled = N'(w_qm_ext << w_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_NORM;
      S_NORM:  w_state_next = (r_b == '0) ? S_SHIFT : S_DIV;
      S_DIV:   if (r_cnt == CW'(1)) w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ka  <= '0;
      r_kb  <= '0;
      r_bh  <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a   <= a;
          r_b   <= b;
          r_dbz <= 1'b0;
        end
        S_NORM: begin
          r_ka  <= w_ka;
          r_kb  <= w_kb;
          r_bh  <= w_bh;
          r_quo <= {w_ah, F'(0)};
          r_rem <= '0;
          r_cnt <= CW'(DW);
          if (r_b == '0) begin
            r_q   <= '1;
            r_dbz <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[DW-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_SHIFT: if (!r_dbz) r_q <= w_q_scaled;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign q         = r_q;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_loba0_div_seq.sv
// Bench for loba0_div_seq: arithmetic reference model plus directed vectors
// with hand-derived quotients, latencies, backpressure and mid-operation reset.
module tb_loba0_div_seq;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready, out_valid, dbz;
  logic [N-1:0] q;

  loba0_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [15:0] q; logic dbz; } res_t;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int lead(input logic [15:0] x);
    int k = 0;
    for (int i = 0; i < 16; i++) if (x[i]) k = i;
    return k;
  endfunction

  // Window = top 4 bits of the left-aligned operand; Qm = floor(Ah*2^8/Bh); scale by 2^(ka-kb-8).
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    res_t r;
    int ka, kb, ah, bh, qm, s;
    longint v;
    if (y == 0) begin
      r.q = 16'hFFFF;
      r.dbz = 1'b1;
      return r;
    end
    ka = lead(x);
    kb = lead(y);
    ah = (int'(x) * (1 << (15 - ka))) / 4096;
    bh = (int'(y) * (1 << (15 - kb))) / 4096;
    qm = (ah * 256) / bh;
    s  = ka - kb - 8;
    if (s >= 0) v = longint'(qm) * (longint'(1) << s);
    else        v = longint'(qm) / (longint'(1) << (-s));
    r.q = v[15:0];
    r.dbz = 1'b0;
    return r;
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding model entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("mon_q", {16'd0, q}, {16'd0, exp_q[0].q});
        chk("mon_dbz", {31'd0, dbz}, {31'd0, exp_q[0].dbz});
        chk("mon_in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] lit_q,
                        input logic lit_dbz, input int lit_lat, input int stall);
    res_t m;
    int lat;
    logic [15:0] held_q;
    m = model(xa, xb);
    chk("model_vs_hand_q", {16'd0, m.q}, {16'd0, lit_q});
    wait_idle();
    a = xa;
    b = xb;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~xa;
    b = ~xb;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, lit_lat);
    chk("q_hand", {16'd0, q}, {16'd0, lit_q});
    chk("dbz_hand", {31'd0, dbz}, {31'd0, lit_dbz});
    held_q = q;
    if (stall > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_q_stable", {16'd0, q}, {16'd0, held_q});
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    $display("op a=%0d b=%0d q=%0d dbz=%0d latency=%0d stall=%0d", xa, xb, held_q, lit_dbz, lat, stall);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {16'd0, q}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd100,   16'd7,     16'd13,     1'b0, 14, 0);
    run_op(16'd65535, 16'd1,     16'd61440,  1'b0, 14, 0);
    run_op(16'd48,    16'd48,    16'd1,      1'b0, 14, 0);
    run_op(16'd1,     16'd65535, 16'd0,      1'b0, 14, 0);
    run_op(16'd0,     16'd5,     16'd0,      1'b0, 14, 0);
    run_op(16'd1000,  16'd0,     16'hFFFF,   1'b1, 2,  0);
    run_op(16'd10,    16'd3,     16'd3,      1'b0, 14, 5);

    // Abort an operation six edges after accept with an asynchronous reset.
    wait_idle();
    a = 16'd100;
    b = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_q", {16'd0, q}, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'd100, 16'd7, 16'd13, 1'b0, 14, 0);

    chk("pending_results", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
